// File: rtl/mcs4_clock_gen.sv
// mcs4_clock_gen: MCS-4 two-phase clock, strobes, machine-cycle index and cpu reset from the PLL clock
// Optional single-step hold (step_mode/step_req/held) is enabled by defining MCS4_STEP_EN
module mcs4_clock_gen #(
  parameter int QUARTER    = 23,
  parameter int RESET_CLKS = 64
) (
  input  logic       clk,
  input  logic       reset,
`ifdef MCS4_STEP_EN
  input  logic       step_mode,
  input  logic       step_req,
  output logic       held,
`endif
  output logic       phi1,
  output logic       phi2,
  output logic       phi1_rise,
  output logic       phi2_fall,
  output logic [2:0] mcyc,
  output logic       sync,
  output logic       cpu_reset
);
  localparam int QW = QUARTER > 1 ? $clog2(QUARTER) : 1;
  localparam int RW = $clog2(RESET_CLKS + 1);
  localparam logic [QW-1:0] QLAST = QW'(QUARTER - 1);
  localparam logic [RW-1:0] RLAST = RW'(RESET_CLKS);
  logic [QW-1:0] qcnt_q, qcnt_d;
  logic [1:0] q_q, q_d;
  logic [2:0] mcyc_q, mcyc_d;
  logic [RW-1:0] per_q, per_d;
  logic active_q, phi1_q, phi2_q, rise_q, fall_q, sync_q, cpu_reset_q;
  logic period_end, cycle_end, hold_d;
  // active_q low means the next edge enters quarter 0 instead of advancing
  assign period_end = active_q && q_q == 2'd3 && qcnt_q == QLAST;
  assign cycle_end  = period_end && mcyc_q == 3'd7;
  always_comb begin
    qcnt_d = '0;
    q_d    = '0;
    mcyc_d = '0;
    per_d  = period_end && per_q != RLAST ? per_q + 1'b1 : per_q;
    if (active_q && !hold_d) begin
      qcnt_d = qcnt_q == QLAST ? '0 : qcnt_q + 1'b1;
      q_d    = qcnt_q == QLAST ? q_q + 2'd1 : q_q;
      mcyc_d = period_end ? mcyc_q + 3'd1 : mcyc_q;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      qcnt_q      <= '0;
      q_q         <= '0;
      mcyc_q      <= '0;
      per_q       <= '0;
      active_q    <= 1'b0;
      phi1_q      <= 1'b0;
      phi2_q      <= 1'b0;
      rise_q      <= 1'b0;
      fall_q      <= 1'b0;
      sync_q      <= 1'b0;
      cpu_reset_q <= 1'b1;
    end else begin
      qcnt_q      <= qcnt_d;
      q_q         <= q_d;
      mcyc_q      <= mcyc_d;
      per_q       <= per_d;
      active_q    <= !hold_d;
      phi1_q      <= !hold_d && q_d == 2'd0;
      phi2_q      <= q_d == 2'd2;
      rise_q      <= !hold_d && q_d == 2'd0 && qcnt_d == '0;
      fall_q      <= q_d == 2'd2 && qcnt_d == QLAST;
      sync_q      <= mcyc_d == 3'd7;
      cpu_reset_q <= per_d != RLAST;
    end
  end
`ifdef MCS4_STEP_EN
  typedef enum logic [1:0] {RUN, HOLD, STEP} state_t;
  state_t st_q;
  logic [2:0] req_q;
  logic held_q, req_edge;
  assign req_edge = req_q[1] && !req_q[2];
  assign hold_d = st_q == HOLD ? step_mode && !req_edge
                               : cycle_end && !cpu_reset_q && (step_mode || st_q == STEP);
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q   <= RUN;
      req_q  <= '0;
      held_q <= 1'b0;
    end else begin
      st_q   <= hold_d ? HOLD : st_q == HOLD ? (step_mode ? STEP : RUN) : st_q;
      req_q  <= {req_q[1:0], step_req};
      held_q <= hold_d;
    end
  end
  assign held = held_q;
`else
  assign hold_d = 1'b0;
`endif
  assign phi1      = phi1_q;
  assign phi2      = phi2_q;
  assign phi1_rise = rise_q;
  assign phi2_fall = fall_q;
  assign mcyc      = mcyc_q;
  assign sync      = sync_q;
  assign cpu_reset = cpu_reset_q;
endmodule
